// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared FSM encoding, arbitration constants and sizing helper for unified_mem_ctrl
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Wait counter holds WAIT_CYCLES-1, and WAIT_CYCLES is at most 7.
    localparam int CNT_W = 3;

    function automatic int idx_w(input int depth_words);
        return (depth_words > 1) ? $clog2(depth_words) : 1;
    endfunction

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port word RAM, synchronous byte-lane write, combinational read
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = idx_w(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic [3:0]       we_i,
    input  logic [IDX_W-1:0] widx_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    // Read is combinational so the access cycle returns the word as it was before the write lands.
    assign rdata_o = mem_q[widx_i];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) begin
                mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/unified_mem_ctrl.sv
// rtl/unified_mem_ctrl.sv - shared inst/data word memory with arbiter, wait states and ready handshake
module unified_mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1,
    parameter int ARB_MODE    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_ready,
    input  logic              d_req,
    input  logic [3:0]        d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ready,
    output logic              busy
);

    localparam int IDX_W = idx_w(DEPTH_WORDS);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gnt_data_q, gnt_data_d;
    logic             rr_data_q, rr_data_d;
    logic             pick_data;
    logic [IDX_W-1:0] widx_q, widx_d;
    logic [3:0]       we_q, we_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      i_rdata_q, d_rdata_q;
    logic [31:0]      ram_rdata;
    logic [3:0]       ram_we;
    logic             resp;

    // Only the word-index bits of each address select storage; the rest wrap away.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr, d_addr};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gnt_data_d = gnt_data_q;
        rr_data_d  = rr_data_q;
        widx_d     = widx_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        pick_data  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    if (i_req && d_req) begin
                        pick_data = (ARB_MODE == ARB_RR) ? rr_data_q : 1'b1;
                    end else begin
                        pick_data = d_req;
                    end
                    gnt_data_d = pick_data;
                    rr_data_d  = ~pick_data;
                    widx_d     = pick_data ? d_addr[IDX_W+1:2] : i_addr[IDX_W+1:2];
                    we_d       = pick_data ? d_we : 4'b0000;
                    wdata_d    = d_wdata;
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            gnt_data_q <= 1'b0;
            rr_data_q  <= 1'b0;
            widx_q     <= '0;
            we_q       <= 4'b0000;
            wdata_q    <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_data_q <= gnt_data_d;
            rr_data_q  <= rr_data_d;
            widx_q     <= widx_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if (i_ready) i_rdata_q <= ram_rdata;
            if (d_ready) d_rdata_q <= ram_rdata;
        end
    end

    assign resp    = (state_q == ST_RESP);
    assign busy    = (state_q != ST_IDLE);
    assign i_ready = resp && !gnt_data_q;
    assign d_ready = resp && gnt_data_q;
    assign ram_we  = d_ready ? we_q : 4'b0000;

    // The ready cycle shows the array word directly; afterwards the captured copy is held.
    assign i_rdata = i_ready ? ram_rdata : i_rdata_q;
    assign d_rdata = d_ready ? ram_rdata : d_rdata_q;

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .we_i    (ram_we),
        .widx_i  (widx_q),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// tb/tb_unified_mem_ctrl.sv - randomized scoreboard bench for unified_mem_ctrl over three configurations
module tb_unified_mem_ctrl;

    typedef struct packed {
        logic [9:0]  widx;
        logic [3:0]  we;
        logic [31:0] wdata;
    } txn_t;

    logic       clk = 1'b0;
    int         n_cmp = 0;
    int         n_fail = 0;
    logic [2:0] done = 3'b000;

    always #5 clk = ~clk;

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [cfg%0d] t=%0t: got %h, expected %h", name, inst, $time, act, exp);
        end
    endtask

    function automatic int pool(input int k);
        case (k)
            0: return 0;
            1: return 1;
            2: return 4;
            3: return 5;
            4: return 8;
            5: return 255;
            6: return 256;
            7: return 1022;
            default: return 1023;
        endcase
    endfunction

    // Byte address for a word: random low bits and random aliasing bits above the 4 KiB array span.
    function automatic logic [31:0] mk_addr(input int widx);
        logic [31:0] a;
        a = 32'(widx * 4) | 32'($urandom_range(0, 3)) | (32'($urandom_range(0, 7)) << 12);
        return a;
    endfunction

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : h
            localparam int W = (g == 0) ? 1 : ((g == 1) ? 2 : 0);
            localparam int A = (g == 0) ? 0 : 1;

            logic        rst;
            logic        i_req, d_req;
            logic [31:0] i_addr, d_addr, d_wdata;
            logic [3:0]  d_we;
            logic [31:0] i_rdata, d_rdata;
            logic        i_ready, d_ready, busy;

            unified_mem_ctrl #(
                .ADDR_W      (32),
                .DEPTH_WORDS (1024),
                .WAIT_CYCLES (W),
                .ARB_MODE    (A)
            ) dut (
                .clk     (clk),
                .rst     (rst),
                .i_req   (i_req),
                .i_addr  (i_addr),
                .i_rdata (i_rdata),
                .i_ready (i_ready),
                .d_req   (d_req),
                .d_we    (d_we),
                .d_addr  (d_addr),
                .d_wdata (d_wdata),
                .d_rdata (d_rdata),
                .d_ready (d_ready),
                .busy    (busy)
            );

            txn_t        iq[$];
            txn_t        dq[$];
            logic [31:0] mem_m [int];
            int          cyc = 0;
            int          next_free = 0;
            int          exp_ready = -10;
            int          last_grant = -10;
            int          exp_port = 0;
            int          last_port = 1;
            logic        hold = 1'b1;
            logic        pre_done = 1'b0;
            logic [31:0] last_i = '0;
            logic [31:0] last_d = '0;

            // Reference model: a grant is taken whenever the controller is free and a request is up;
            // the response lands W+1 cycles later and the controller is free again one cycle after that.
            initial begin
                txn_t        t;
                logic [31:0] e, nv;
                int          pick;
                forever begin
                    @(negedge clk);
                    if (!hold) begin
                        check("i_ready", g, 32'(i_ready), 32'(cyc == exp_ready && exp_port == 0));
                        check("d_ready", g, 32'(d_ready), 32'(cyc == exp_ready && exp_port == 1));
                        check("busy", g, 32'(busy), 32'(cyc > last_grant && cyc <= exp_ready));
                        if (d_ready) begin
                            if (dq.size() == 0) begin
                                check("d_queue_nonempty", g, 32'(dq.size()), 32'd1);
                            end else begin
                                t = dq.pop_front();
                                if (mem_m.exists(int'(t.widx))) begin
                                    e = mem_m[int'(t.widx)];
                                    check("d_rdata", g, d_rdata, e);
                                    last_d = e;
                                end else begin
                                    last_d = d_rdata;
                                end
                                if (t.we != 4'b0000) begin
                                    nv = mem_m.exists(int'(t.widx)) ? mem_m[int'(t.widx)] : 32'h0;
                                    for (int b = 0; b < 4; b++) begin
                                        if (t.we[b]) nv[8*b +: 8] = t.wdata[8*b +: 8];
                                    end
                                    if (t.we == 4'hF || mem_m.exists(int'(t.widx))) mem_m[int'(t.widx)] = nv;
                                end
                            end
                        end else begin
                            check("d_rdata_hold", g, d_rdata, last_d);
                        end
                        if (i_ready) begin
                            if (iq.size() == 0) begin
                                check("i_queue_nonempty", g, 32'(iq.size()), 32'd1);
                            end else begin
                                t = iq.pop_front();
                                if (mem_m.exists(int'(t.widx))) begin
                                    e = mem_m[int'(t.widx)];
                                    check("i_rdata", g, i_rdata, e);
                                    last_i = e;
                                end else begin
                                    last_i = i_rdata;
                                end
                            end
                        end else begin
                            check("i_rdata_hold", g, i_rdata, last_i);
                        end
                        if (cyc >= next_free && (i_req || d_req)) begin
                            if (i_req && d_req) pick = (A == 0) ? 1 : ((last_port == 0) ? 1 : 0);
                            else pick = d_req ? 1 : 0;
                            exp_port   = pick;
                            last_port  = pick;
                            last_grant = cyc;
                            exp_ready  = cyc + W + 1;
                            next_free  = cyc + W + 2;
                        end
                    end
                    cyc++;
                end
            end

            task automatic d_access(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd);
                txn_t t;
                int   k;
                t.widx  = 10'((addr % 32'd4096) / 32'd4);
                t.we    = we;
                t.wdata = wd;
                dq.push_back(t);
                d_addr  = addr;
                d_we    = we;
                d_wdata = wd;
                d_req   = 1'b1;
                for (k = 0; k < 100; k++) begin
                    @(negedge clk);
                    if (d_ready) break;
                end
                if (k == 100) check("d_ready_timeout", g, 32'(d_ready), 32'd1);
                @(posedge clk);
                #1;
            endtask

            task automatic i_fetch(input logic [31:0] addr);
                txn_t t;
                int   k;
                t.widx  = 10'((addr % 32'd4096) / 32'd4);
                t.we    = 4'b0000;
                t.wdata = '0;
                iq.push_back(t);
                i_addr = addr;
                i_req  = 1'b1;
                for (k = 0; k < 100; k++) begin
                    @(negedge clk);
                    if (i_ready) break;
                end
                if (k == 100) check("i_ready_timeout", g, 32'(i_ready), 32'd1);
                @(posedge clk);
                #1;
            endtask

            initial begin
                int idle;
                rst = 1'b1;
                i_req = 1'b0; i_addr = '0;
                d_req = 1'b0; d_addr = '0; d_we = '0; d_wdata = '0;
                repeat (3) @(negedge clk);
                check("rst_i_ready", g, 32'(i_ready), 32'd0);
                check("rst_d_ready", g, 32'(d_ready), 32'd0);
                check("rst_busy", g, 32'(busy), 32'd0);
                check("rst_i_rdata", g, i_rdata, 32'd0);
                check("rst_d_rdata", g, d_rdata, 32'd0);
                @(posedge clk);
                #1;
                rst  = 1'b0;
                hold = 1'b0;
                fork
                    begin
                        for (int k = 0; k < 9; k++) d_access(mk_addr(pool(k)), 4'hF, $urandom);
                        d_access(32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
                        d_access(32'h0000_0010, 4'h3, 32'h0000_1234);
                        d_access(32'h0000_0010, 4'h0, 32'h0);
                        d_req    = 1'b0;
                        pre_done = 1'b1;
                        repeat (60) begin
                            idle = $urandom_range(0, 2);
                            if (idle > 0) begin
                                d_req = 1'b0;
                                repeat (idle) @(posedge clk);
                                #1;
                            end
                            d_access(mk_addr(pool($urandom_range(0, 8))),
                                     ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                                     $urandom);
                        end
                        d_req = 1'b0;
                    end
                    begin
                        wait (pre_done);
                        @(posedge clk);
                        #1;
                        repeat (60) begin
                            idle = $urandom_range(0, 2);
                            if (idle > 0) begin
                                i_req = 1'b0;
                                repeat (idle) @(posedge clk);
                                #1;
                            end
                            i_fetch(mk_addr(pool($urandom_range(0, 8))));
                        end
                        i_req = 1'b0;
                    end
                join

                // Abort a granted write to word 8 with reset; the word must keep its old value.
                @(posedge clk);
                #1;
                hold    = 1'b1;
                d_addr  = 32'h0000_0020;
                d_we    = 4'hF;
                d_wdata = ~mem_m[8];
                d_req   = 1'b1;
                @(posedge clk);
                #1;
                check("busy_after_grant", g, 32'(busy), 32'd1);
                d_req = 1'b0;
                rst   = 1'b1;
                #1;
                check("abort_i_ready", g, 32'(i_ready), 32'd0);
                check("abort_d_ready", g, 32'(d_ready), 32'd0);
                check("abort_busy", g, 32'(busy), 32'd0);
                check("abort_i_rdata", g, i_rdata, 32'd0);
                check("abort_d_rdata", g, d_rdata, 32'd0);
                repeat (3) begin
                    @(negedge clk);
                    check("abort_no_d_ready", g, 32'(d_ready), 32'd0);
                end
                @(posedge clk);
                #1;
                rst        = 1'b0;
                next_free  = 0;
                exp_ready  = -10;
                last_grant = -10;
                last_port  = 1;
                last_i     = '0;
                last_d     = '0;
                hold       = 1'b0;
                d_access(32'h0000_0020, 4'h0, 32'h0);
                d_req = 1'b0;
                i_fetch(32'h0000_1023);
                i_req = 1'b0;
                repeat (4) @(negedge clk);
                done[g] = 1'b1;
            end
        end
    endgenerate

    initial begin
        int t;
        for (t = 0; t < 20000 && done != 3'b111; t++) @(posedge clk);
        if (done != 3'b111) begin
            n_cmp++;
            n_fail++;
            $display("FAIL watchdog: done flags %b, expected 111", done);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/unified_mem_ctrl.md
Name: unified_mem_ctrl

Overview:
Parametrised successor to the split inst/data memory arrangement of the current MIPS top level. One byte-writable word array is shared by the core's instruction port and data port. A small arbiter and FSM add configurable wait states and a ready handshake, so the core can stall on memory instead of relying on inverted-clock single-cycle access. Sits between mips and the memory array in the next-generation top.

Parameters:
ADDR_W, 32, width of i_addr/d_addr (byte addresses)
DEPTH_WORDS, 1024, number of 32-bit words (power of 2, >=2)
WAIT_CYCLES, 1, extra cycles between grant and response (0..7)
ARB_MODE, 0, 0 = data port fixed priority; 1 = round-robin between ports

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
i_req  in  1  instruction fetch request, held until i_ready
i_addr  in  ADDR_W  fetch byte address
i_rdata  out  32  fetched word, valid when i_ready=1
i_ready  out  1  one-cycle completion pulse for fetch
d_req  in  1  data access request, held until d_ready
d_we  in  4  byte-lane write enables (bit n = bits 8n+7:8n); 0000 = read
d_addr  in  ADDR_W  data byte address
d_wdata  in  32  store data
d_rdata  out  32  load data, valid when d_ready=1
d_ready  out  1  one-cycle completion pulse for data access
busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Reset (async, any state): FSM->IDLE; i_ready=d_ready=0; i_rdata=d_rdata=0; busy=0; wait counter=0; RR pointer->instruction port. Array contents are not reset. An access in flight at reset is aborted; no write occurs.
- States: IDLE, WAIT, RESP.
- IDLE: if any req high, grant one port and latch its addr/we/wdata. Go to WAIT if WAIT_CYCLES>0 (counter=WAIT_CYCLES-1), else RESP. With no req, stay in IDLE.
- Arbitration when both req high: ARB_MODE=0 grants the data port. ARB_MODE=1 grants the port not granted last; the pointer updates on each grant.
- WAIT: decrement counter; go to RESP when counter==0.
- RESP: perform the array access and pulse the granted port's ready for exactly one cycle with its rdata; next state IDLE. The other port's ready stays 0.
- Latency: req sampled in IDLE at cycle 0 -> ready at cycle WAIT_CYCLES+1. Minimum spacing between grants is WAIT_CYCLES+2 cycles.
- Write: bytes with d_we set are updated in RESP. d_rdata returns the pre-write word. Bytes with we=0 are unchanged.
- Word index = addr[$clog2(DEPTH_WORDS)+1:2]. Low 2 bits are ignored (no misalign trap). Upper bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- rdata holds its last value when ready=0.
- Req held high after ready is treated as a new request in the next IDLE cycle, using the address presented then.
- Req dropped before ready: the latched access still completes, and ready pulses anyway.
- Changing addr/we/wdata after grant has no effect on the access in flight.

Decomposition:
- Shared package mem_pkg: FSM state encoding (IDLE/WAIT/RESP), ARB_FIXED/ARB_RR constants, word-index width function.
- One sub-module, mem_array: single-port synchronous word RAM with 4-bit byte write enable, parameter DEPTH_WORDS. It is read and written in RESP.
- Arbiter and FSM stay in unified_mem_ctrl.

Test Plan:
- Reset, then i_req with i_addr=0x0, WAIT_CYCLES=1 -> i_ready pulses at cycle 2, i_rdata=preloaded word 0; busy high for cycles 1-2.
- d_we=1111, d_addr=0x10, d_wdata=0xDEADBEEF, then d_we=0011 with d_wdata=0x00001234, then a read -> d_rdata=0xDEAD1234; the second write returns 0xDEADBEEF.
- i_req and d_req both high with ARB_MODE=0 -> d_ready first, i_ready WAIT_CYCLES+2 cycles later. With ARB_MODE=1 and both held, grants alternate I,D,I,D.
- DEPTH_WORDS=1024, write 0x55AA55AA at 0x1000 -> read at 0x0000 returns 0x55AA55AA (wrap). A read at 0x0003 equals a read at 0x0000.
- Assert rst during WAIT of a write to 0x20 -> no ready pulse, all outputs 0, word 0x20 unchanged on a later read.
- WAIT_CYCLES=0 with i_req held continuously -> i_ready every 2nd cycle; i_rdata tracks each new i_addr.
